wavetable_poly: RTL and testbench
=================================

WAVETABLE_POLY -- requirements
Module: wavetable_poly

Interface
REQ-001 Parameter VOICES, default 4, is the number of independent voices, range 1..8.
REQ-002 Parameter POS_W, default 13, is the integer wave-position width (table depth 2^POS_W samples).
REQ-003 Parameter FRAC_W, default 4, is the fractional phase bits below the position.
REQ-004 Parameter WSEL_W, default 2, is the wave-select width (number of tables is 2^WSEL_W).
REQ-005 Parameter DATA_W, fixed at 16, is the sample width (signed two's complement).
REQ-006 clk_50  in  1  is the single system clock; all logic SHALL be rising-edge on clk_50.
REQ-007 ar  in  1  is the asynchronous active-low reset.
REQ-008 sample_tick  in  1  is a one-cycle pulse, synchronous to clk_50, once per audio frame (48.8 kHz).
REQ-009 waveSelect  in  WSEL_W  is the table select, sampled once per frame on sample_tick.
REQ-010 keyOn  in  VOICES  is the per-voice gate, 1 = pressed.
REQ-011 keyVal  in  4*VOICES  gives the per-voice note 0..12 (A..A), with voice v at bits [4v+3:4v].
REQ-012 octave  in  2*VOICES  is the per-voice octave shift 0..3, applied as a left shift of the increment.
REQ-013 mem_addr  out  WSEL_W+POS_W  is the read address {waveSelect_latched, position}.
REQ-014 mem_rd  out  1  is a one-cycle read request.
REQ-015 mem_data  in  DATA_W  is the read data, little-endian byte order, valid when mem_done=1.
REQ-016 mem_done  in  1  is a one-cycle read-complete strobe.
REQ-017 dataOut  out  16  is the mixed sample, big-endian (byte-swapped) for the codec.
REQ-018 dataValid  out  1  is a one-cycle pulse when dataOut updates.
REQ-019 busy  out  1  is high from accepted sample_tick until the dataValid cycle inclusive.
REQ-020 overrun  out  1  is a sticky flag, set when sample_tick arrives while busy.

Function
REQ-021 Increment table: note 0..12 → 74,78,83,88,93,99,104,111,117,124,132,139,148; inc = (table << FRAC_W) << octave.
REQ-022 A voice is active iff keyOn[v]=1 and keyVal[v]<=12; keyVal 13..15 SHALL be treated as key-off.
REQ-023 Phase accumulator per voice: POS_W+FRAC_W bits unsigned, wraps modulo 2^(POS_W+FRAC_W) with no saturation.
REQ-024 FSM states: IDLE, STEP, ISSUE, WAIT, NEXT, OUT.
REQ-025 IDLE→STEP on sample_tick, latching waveSelect and setting busy.
REQ-026 STEP (1 cycle): each active voice phase += inc; each inactive voice phase := 0; voice index := 0.
REQ-027 ISSUE: if voice index is active, assert mem_rd for 1 cycle with position = phase[POS_W+FRAC_W-1:FRAC_W], then go to WAIT; if inactive, go to NEXT with no read.
REQ-028 WAIT: hold until mem_done; on mem_done, byte-swap mem_data to big-endian, sign-extend, add to the accumulator; go to NEXT.
REQ-029 WAIT timeout: 64 cycles without mem_done SHALL contribute 0 and go to NEXT.
REQ-030 NEXT: if index = VOICES-1 go to OUT, else index+1 and go to ISSUE.
REQ-031 Accumulator width is 16+clog2(VOICES) signed, cleared in STEP.
REQ-032 OUT: dataOut := sum saturated to [-32768, 32767], stored byte-swapped; dataValid=1 for 1 cycle; busy clears the next cycle; go to IDLE.
REQ-033 No active voices: no mem_rd issued; dataOut := 0 with dataValid still pulsed.
REQ-034 sample_tick while busy: ignored, overrun := 1 (cleared only by reset).
REQ-035 keyOn/keyVal/octave changes take effect at the next STEP only.
REQ-036 Reads use post-increment phase.

Reset
REQ-037 On ar=0: state=IDLE, all phases=0, accumulator=0, dataOut=0, dataValid=0, mem_rd=0, mem_addr=0, busy=0, overrun=0.
REQ-038 Reset mid-frame SHALL abandon the frame; no dataValid follows until a new sample_tick after ar release.

Verification
REQ-039 VOICES=4, voice0 keyVal=0 octave=0, 3 ticks → mem_addr positions 74, 148, 222; one mem_rd per frame.
REQ-040 Phase preset near top: position 8150 + inc 74 → next read position 32 (wrap), no glitch in FSM.
REQ-041 4 voices active, mem_data little-endian 0xFF7F (=0x7FFF) each → dataOut stored as swap(0x7FFF) = 0xFF7F, saturated; likewise 4×0x0080 (=0x8000) → -32768.
REQ-042 keyVal=13 with keyOn=1 → voice skipped, phase reads 0; all voices off → dataOut=0, dataValid pulse, zero mem_rd.
REQ-043 sample_tick during WAIT → overrun=1, frame completes normally; mem_done withheld 64 cycles → voice contributes 0.
REQ-044 ar low during WAIT → all outputs 0 at once; after release no dataValid until the next tick.

Source files
------------

// File: rtl/wavetable_poly.sv
// Polyphonic wavetable voice engine: per-frame phase stepping, one table read per
// active voice, signed mix with saturation, byte-swapped output for the codec.
module wavetable_poly #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned POS_W  = 13,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned WSEL_W = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic                      clk_50,
  input  logic                      ar,
  input  logic                      sample_tick,
  input  logic [WSEL_W-1:0]         waveSelect,
  input  logic [VOICES-1:0]         keyOn,
  input  logic [4*VOICES-1:0]       keyVal,
  input  logic [2*VOICES-1:0]       octave,
  output logic [WSEL_W+POS_W-1:0]   mem_addr,
  output logic                      mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_done,
  output logic [15:0]               dataOut,
  output logic                      dataValid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned PhW  = POS_W + FRAC_W;
  localparam int unsigned AccW = 16 + $clog2(VOICES);
  localparam int unsigned IdxW = (VOICES > 1) ? $clog2(VOICES) : 1;

  localparam logic signed [AccW-1:0] SatMax = AccW'(32767);
  localparam logic signed [AccW-1:0] SatMin = AccW'(-32768);

  typedef enum logic [2:0] {StIdle, StStep, StIssue, StWait, StNext, StOut} state_e;

  state_e                   state_q, state_d;
  logic [PhW-1:0]           phase_q [VOICES];
  logic [PhW-1:0]           phase_d [VOICES];
  logic [VOICES-1:0]        active_q, active_d;
  logic [WSEL_W-1:0]        wsel_q, wsel_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic [5:0]               wait_cnt_q, wait_cnt_d;
  logic [WSEL_W+POS_W-1:0]  mem_addr_q, mem_addr_d;
  logic                     mem_rd_q, mem_rd_d;
  logic [15:0]              data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     overrun_q, overrun_d;

  logic [VOICES-1:0]        voice_on;
  logic [PhW-1:0]           voice_inc [VOICES];
  logic signed [15:0]       mem_sw;
  logic signed [AccW-1:0]   acc_sat;

  // Base increment per note (A..A); notes above 12 never reach here as active
  function automatic logic [PhW-1:0] note_inc(input logic [3:0] note, input logic [1:0] oct);
    logic [7:0] base;
    case (note)
      4'd0:    base = 8'd74;
      4'd1:    base = 8'd78;
      4'd2:    base = 8'd83;
      4'd3:    base = 8'd88;
      4'd4:    base = 8'd93;
      4'd5:    base = 8'd99;
      4'd6:    base = 8'd104;
      4'd7:    base = 8'd111;
      4'd8:    base = 8'd117;
      4'd9:    base = 8'd124;
      4'd10:   base = 8'd132;
      4'd11:   base = 8'd139;
      4'd12:   base = 8'd148;
      default: base = 8'd0;
    endcase
    return PhW'(base) << (FRAC_W + 32'(oct));
  endfunction

  // Decode live key inputs; only consumed in StStep so changes land on frame boundaries
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      voice_on[v]  = keyOn[v] && (keyVal[4*v +: 4] <= 4'd12);
      voice_inc[v] = note_inc(keyVal[4*v +: 4], octave[2*v +: 2]);
    end
  end

  // Table data arrives little-endian; swap to native order before mixing
  assign mem_sw = {mem_data[7:0], mem_data[15:8]};

  // Clamp the mix to 16-bit signed range
  always_comb begin
    if (acc_q > SatMax)      acc_sat = SatMax;
    else if (acc_q < SatMin) acc_sat = SatMin;
    else                     acc_sat = acc_q;
  end

  // Frame sequencer: next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    active_d     = active_q;
    wsel_d       = wsel_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    wait_cnt_d   = wait_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overrun_d    = overrun_q;

    if (sample_tick && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          wsel_d  = waveSelect;
          state_d = StStep;
        end
      end
      StStep: begin
        for (int v = 0; v < VOICES; v++) begin
          phase_d[v] = voice_on[v] ? phase_q[v] + voice_inc[v] : '0;
        end
        active_d = voice_on;
        idx_d    = '0;
        acc_d    = '0;
        state_d  = StIssue;
      end
      StIssue: begin
        if (active_q[idx_q]) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {wsel_q, phase_q[idx_q][PhW-1:FRAC_W]};
          wait_cnt_d = '0;
          state_d    = StWait;
        end else begin
          state_d = StNext;
        end
      end
      StWait: begin
        if (mem_done) begin
          acc_d   = acc_q + AccW'(mem_sw);
          state_d = StNext;
        end else if (wait_cnt_q == 6'd63) begin
          // Memory never answered: voice contributes silence
          state_d = StNext;
        end else begin
          wait_cnt_d = wait_cnt_q + 6'd1;
        end
      end
      StNext: begin
        if (idx_q == IdxW'(VOICES - 1)) begin
          data_out_d   = {acc_sat[7:0], acc_sat[15:8]};
          data_valid_d = 1'b1;
          state_d      = StOut;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StIssue;
        end
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      state_q      <= StIdle;
      for (int v = 0; v < VOICES; v++) phase_q[v] <= '0;
      active_q     <= '0;
      wsel_q       <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      wait_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      active_q     <= active_d;
      wsel_q       <= wsel_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign dataOut   = data_out_q;
  assign dataValid = data_valid_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_wavetable_poly.sv
// Directed bench for wavetable_poly with a simple latency-programmable memory responder.
module tb_wavetable_poly;

  logic        clk_50 = 1'b0;
  logic        ar;
  logic        sample_tick;
  logic [1:0]  waveSelect;
  logic [3:0]  keyOn;
  logic [15:0] keyVal;
  logic [7:0]  octave;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_done;
  logic [15:0] dataOut;
  logic        dataValid;
  logic        busy;
  logic        overrun;

  int n_total = 0;
  int n_bad   = 0;

  // Responder controls
  logic [15:0] resp_data = 16'h0000;
  int          resp_lat  = 2;
  logic        withhold  = 1'b0;
  int          lat_cnt;
  int          rd_cnt    = 0;

  wavetable_poly dut (
    .clk_50      (clk_50),
    .ar          (ar),
    .sample_tick (sample_tick),
    .waveSelect  (waveSelect),
    .keyOn       (keyOn),
    .keyVal      (keyVal),
    .octave      (octave),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_done    (mem_done),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #10 clk_50 = ~clk_50;

  // Memory model: answers each read after resp_lat cycles unless withheld
  always @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      lat_cnt  <= 0;
      mem_done <= 1'b0;
      mem_data <= 16'h0000;
    end else begin
      mem_done <= 1'b0;
      if (mem_rd) begin
        rd_cnt  <= rd_cnt + 1;
        lat_cnt <= resp_lat;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1 && !withhold) begin
          mem_done <= 1'b1;
          mem_data <= resp_data;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output logic ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      cyc = i;
      if (dataValid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_50);
    end
  endtask

  task automatic do_frame(output logic ok, output int cyc);
    @(negedge clk_50);
    sample_tick = 1'b1;
    @(negedge clk_50);
    sample_tick = 1'b0;
    wait_valid(ok, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    ar = 1'b0;
    repeat (2) @(negedge clk_50);
    ar = 1'b1;
    @(negedge clk_50);
  endtask

  logic ok;
  int   cyc;
  int   rd0;
  int   dv_seen;

  initial begin
    ar = 1'b0; sample_tick = 1'b0; waveSelect = 2'd0;
    keyOn = 4'b0000; keyVal = 16'h0000; octave = 8'h00;
    repeat (3) @(negedge clk_50);
    chk("rst_dataOut", dataOut, 16'h0000);
    chk("rst_dataValid", dataValid, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 15'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    ar = 1'b1;
    @(negedge clk_50);

    // Single voice, three frames: positions 74/148/222, one read each
    waveSelect = 2'd2; keyOn = 4'b0001; resp_data = 16'h3412;
    for (int f = 1; f <= 3; f++) begin
      rd0 = rd_cnt;
      do_frame(ok, cyc);
      chk("seq_valid", ok, 1'b1);
      chk("seq_addr", mem_addr, {2'd2, 13'(74 * f)});
      chk("seq_rdcnt", rd_cnt - rd0, 1);
      chk("seq_data", dataOut, 16'h3412);
    end

    // Phase wrap: 88*74 + 21*78 = 8150, then +74 wraps to 32
    do_reset();
    waveSelect = 2'd0; keyOn = 4'b0001;
    for (int f = 0; f < 109; f++) begin
      keyVal = (f < 88) ? 16'h0000 : 16'h0001;
      do_frame(ok, cyc);
    end
    chk("wrap_pre", mem_addr, 15'd8150);
    keyVal = 16'h0000;
    do_frame(ok, cyc);
    chk("wrap_valid", ok, 1'b1);
    chk("wrap_post", mem_addr, 15'd32);

    // Four voices: positive and negative saturation, plus an in-range mix
    do_reset();
    waveSelect = 2'd1; keyOn = 4'b1111;
    keyVal = {4'd5, 4'd12, 4'd1, 4'd0};
    octave = {2'd1, 2'd2, 2'd0, 2'd0};
    resp_data = 16'hFF7F;
    rd0 = rd_cnt;
    do_frame(ok, cyc);
    chk("satp_valid", ok, 1'b1);
    chk("satp_data", dataOut, 16'hFF7F);
    chk("satp_rdcnt", rd_cnt - rd0, 4);
    chk("satp_addr_v3", mem_addr, {2'd1, 13'd198});
    resp_data = 16'h0080;
    do_frame(ok, cyc);
    chk("satn_data", dataOut, 16'h0080);
    resp_data = 16'h0010;
    do_frame(ok, cyc);
    chk("mix_data", dataOut, 16'h0040);

    // keyVal 13 is key-off: voice 0 skipped, its phase stays at zero
    do_reset();
    waveSelect = 2'd0; octave = 8'h00;
    keyOn = 4'b0011; keyVal = {4'd0, 4'd0, 4'd0, 4'd13};
    resp_data = 16'h0100;
    rd0 = rd_cnt;
    do_frame(ok, cyc);
    chk("k13_rdcnt", rd_cnt - rd0, 1);
    chk("k13_data", dataOut, 16'h0100);
    chk("k13_addr", mem_addr, 15'd74);
    keyOn = 4'b0001; keyVal = 16'h0000;
    do_frame(ok, cyc);
    chk("k13_phase0", mem_addr, 15'd74);

    // Read timeout: voice contributes zero after 64 idle wait cycles
    withhold = 1'b1;
    rd0 = rd_cnt;
    do_frame(ok, cyc);
    chk("tmo_valid", ok, 1'b1);
    chk("tmo_cycles", cyc, 73);
    chk("tmo_data", dataOut, 16'h0000);
    chk("tmo_rdcnt", rd_cnt - rd0, 1);
    withhold = 1'b0;

    // All voices off: zero output, still pulsed, no reads
    keyOn = 4'b0000;
    rd0 = rd_cnt;
    do_frame(ok, cyc);
    chk("off_valid", ok, 1'b1);
    chk("off_data", dataOut, 16'h0000);
    chk("off_rdcnt", rd_cnt - rd0, 0);

    // Tick during WAIT sets sticky overrun; frame still completes
    keyOn = 4'b0001; resp_lat = 20;
    @(negedge clk_50);
    sample_tick = 1'b1;
    @(negedge clk_50);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk_50);
    chk("ovr_busy", busy, 1'b1);
    chk("ovr_pre", overrun, 1'b0);
    sample_tick = 1'b1;
    @(negedge clk_50);
    sample_tick = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    wait_valid(ok, cyc);
    chk("ovr_valid", ok, 1'b1);
    chk("ovr_data", dataOut, 16'h0100);
    @(negedge clk_50);
    chk("ovr_busy_clr", busy, 1'b0);
    resp_lat = 2;
    do_frame(ok, cyc);
    chk("ovr_sticky", overrun, 1'b1);

    // Reset while stuck in WAIT clears everything immediately
    withhold = 1'b1;
    @(negedge clk_50);
    sample_tick = 1'b1;
    @(negedge clk_50);
    sample_tick = 1'b0;
    repeat (8) @(negedge clk_50);
    chk("arw_busy_pre", busy, 1'b1);
    ar = 1'b0;
    #1;
    chk("arw_busy", busy, 1'b0);
    chk("arw_addr", mem_addr, 15'h0000);
    chk("arw_data", dataOut, 16'h0000);
    chk("arw_ovr", overrun, 1'b0);
    chk("arw_rd", mem_rd, 1'b0);
    @(negedge clk_50);
    ar = 1'b1;
    withhold = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50);
      if (dataValid) dv_seen++;
    end
    chk("arw_no_valid", dv_seen, 0);
    do_frame(ok, cyc);
    chk("arw_new_valid", ok, 1'b1);
    chk("arw_new_addr", mem_addr, 15'd74);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
